// File: rtl/quad_decoder_multi.sv
// quad_decoder_multi: N-channel quadrature encoder front-end.
// Each channel synchronises and glitch-filters its A/B inputs, decodes them
// at 4x resolution into a wrapping signed position count, flags illegal
// (double-bit) transitions and reports velocity as the count change over a
// fixed window shared by all channels.
//
// Build option: define QUAD_INDEX_EN to enable index (Z) zeroing. Without it
// the index input is ignored and no index logic is built.
//
// Handshake: there is no flow control. vel_valid is a one-cycle strobe that
// marks the cycle in which every velocity lane presents a freshly computed
// value; the velocity lanes hold that value until the next strobe.

// Two-flop synchroniser followed by a stability filter: the filtered output
// only follows the synchronised input after FILTER_LEN consecutive cycles of
// disagreement, so shorter pulses never reach the decoder.
module qd_sync_filter #(
  parameter int FILTER_LEN = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_filt
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);

  logic           r_s1;
  logic           r_s2;
  logic           r_filt;
  logic [FCW-1:0] r_cnt;

  // Synchronise, then count cycles of disagreement before accepting a change
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == FLT_LAST) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

module quad_decoder_multi #(
  parameter int NCH        = 1,
  parameter int CW         = 32,
  parameter int VW         = 16,
  parameter int FILTER_LEN = 5,
  parameter int WINDOW     = 16000
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [NCH-1:0]      quadA,
  input  logic [NCH-1:0]      quadB,
  input  logic [NCH-1:0]      index,
  input  logic [NCH-1:0]      clear,
  input  logic                err_clr,
  output logic [NCH*CW-1:0]   count,
  output logic [NCH*VW-1:0]   velocity,
  output logic                vel_valid,
  output logic [NCH-1:0]      err,
  output logic [NCH-1:0]      A_filtered
);

  localparam int WNW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WNW-1:0] WIN_LAST = WNW'(WINDOW - 1);

  logic [WNW-1:0] r_win;
  logic           r_vel_valid;
  logic           w_win_term;

  assign w_win_term = (r_win == WIN_LAST);

  // Free-running velocity window counter shared by every channel
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_win <= '0;
    end else if (w_win_term) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + 1'b1;
    end
  end

  // Velocity strobe: high in the cycle the new velocities become visible
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_vel_valid <= 1'b0;
    end else begin
      r_vel_valid <= w_win_term;
    end
  end

  assign vel_valid = r_vel_valid;

`ifndef QUAD_INDEX_EN
  // Index is intentionally ignored in this build
  logic w_unused_index;
  assign w_unused_index = ^index;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          w_fa;
    logic          w_fb;
    logic [1:0]    w_cur;
    logic [1:0]    r_prev;
    logic          w_up;
    logic          w_dn;
    logic          w_illegal;
    logic          w_idx_hit;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] r_snap;
    logic [CW-1:0] w_diff;
    logic [VW-1:0] w_vel_sat;
    logic [VW-1:0] r_vel;
    logic          r_err;

    qd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_a (
      .i_clk  (CLK),
      .i_rst  (reset),
      .i_raw  (quadA[i]),
      .o_filt (w_fa)
    );

    qd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_b (
      .i_clk  (CLK),
      .i_rst  (reset),
      .i_raw  (quadB[i]),
      .o_filt (w_fb)
    );

    assign w_cur = {w_fa, w_fb};

`ifdef QUAD_INDEX_EN
    logic w_fz;
    logic r_z_prev;

    qd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_z (
      .i_clk  (CLK),
      .i_rst  (reset),
      .i_raw  (index[i]),
      .o_filt (w_fz)
    );

    // Remember filtered index to detect its rising edge
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        r_z_prev <= 1'b0;
      end else begin
        r_z_prev <= w_fz;
      end
    end

    // Index only zeroes the count when the encoder sits in the 00 state
    assign w_idx_hit = w_fz & ~r_z_prev & (w_cur == 2'b00);
`else
    assign w_idx_hit = 1'b0;
`endif

    // Previous filtered A/B state for the transition decoder
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        r_prev <= 2'b00;
      end else begin
        r_prev <= w_cur;
      end
    end

    // 4x decode: Gray sequence 00->10->11->01 counts up, reverse counts down,
    // both bits changing at once is illegal and does not count
    always_comb begin
      w_up      = 1'b0;
      w_dn      = 1'b0;
      w_illegal = 1'b0;
      case ({r_prev, w_cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up      = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_dn      = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
        default: ;
      endcase
    end

    // Next count: clear beats index, index beats a decoded step; wraps freely
    always_comb begin
      w_cnt_next = r_cnt;
      if (clear[i]) begin
        w_cnt_next = '0;
      end else if (w_idx_hit) begin
        w_cnt_next = '0;
      end else if (w_up) begin
        w_cnt_next = r_cnt + CW'(1);
      end else if (w_dn) begin
        w_cnt_next = r_cnt - CW'(1);
      end
    end

    // Position register
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end

    // Difference taken at full count width so it stays correct across wrap
    assign w_diff = w_cnt_next - r_snap;

    if (CW > VW) begin : g_sat
      localparam logic [CW-1:0] VMAX_CW = {{(CW-VW+1){1'b0}}, {(VW-1){1'b1}}};
      localparam logic [CW-1:0] VMIN_CW = {{(CW-VW+1){1'b1}}, {(VW-1){1'b0}}};

      // Clamp the window delta into the signed velocity range
      always_comb begin
        w_vel_sat = w_diff[VW-1:0];
        if ($signed(w_diff) > $signed(VMAX_CW)) begin
          w_vel_sat = {1'b0, {(VW-1){1'b1}}};
        end else if ($signed(w_diff) < $signed(VMIN_CW)) begin
          w_vel_sat = {1'b1, {(VW-1){1'b0}}};
        end
      end
    end else begin : g_ext
      assign w_vel_sat = VW'($signed(w_diff));
    end

    // Window snapshot; a clear or index restarts motion accounting from zero
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        r_snap <= '0;
      end else if (w_win_term) begin
        r_snap <= w_cnt_next;
      end else if (clear[i] || w_idx_hit) begin
        r_snap <= '0;
      end
    end

    // Velocity register, updated once per window
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        r_vel <= '0;
      end else if (w_win_term) begin
        r_vel <= w_vel_sat;
      end
    end

    // Sticky error flag; a new illegal transition wins over err_clr
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        r_err <= 1'b0;
      end else if (w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end

    assign count[i*CW +: CW]    = r_cnt;
    assign velocity[i*VW +: VW] = r_vel;
    assign err[i]               = r_err;
    assign A_filtered[i]        = w_fa;
  end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Testbench for quad_decoder_multi: two channels, 10-bit count, 8-bit velocity,
// FILTER_LEN=5, WINDOW=1000. Table-driven step sequences, hand-written corner
// sequences, and a velocity scoreboard queue popped on each vel_valid.
module tb_quad_decoder_multi;

  localparam int NCH  = 2;
  localparam int CW   = 10;
  localparam int VW   = 8;
  localparam int FLEN = 5;
  localparam int WIN  = 1000;

  logic              CLK = 1'b0;
  logic              reset;
  logic [NCH-1:0]    quadA;
  logic [NCH-1:0]    quadB;
  logic [NCH-1:0]    index;
  logic [NCH-1:0]    clear;
  logic              err_clr;
  logic [NCH*CW-1:0] count;
  logic [NCH*VW-1:0] velocity;
  logic              vel_valid;
  logic [NCH-1:0]    err;
  logic [NCH-1:0]    A_filtered;

  quad_decoder_multi #(
    .NCH(NCH), .CW(CW), .VW(VW), .FILTER_LEN(FLEN), .WINDOW(WIN)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .quadA      (quadA),
    .quadB      (quadB),
    .index      (index),
    .clear      (clear),
    .err_clr    (err_clr),
    .count      (count),
    .velocity   (velocity),
    .vel_valid  (vel_valid),
    .err        (err),
    .A_filtered (A_filtered)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [VW-1:0] exp_q[$];
  int            ph[NCH];
  logic [CW-1:0] m_cnt[NCH];
  int            af_toggles = 0;
  logic          af_prev = 1'b0;

  typedef struct {
    int            ch;
    int            dir;
    int            nsteps;
    int            ph_len;
    bit            do_clr;
    logic [CW-1:0] exp_c0;
    logic [CW-1:0] exp_c1;
    logic [NCH-1:0] exp_err;
  } vec_t;

  vec_t vecs[7];

  // Count every change of channel-0 filtered A
  always @(negedge CLK) begin
    if (A_filtered[0] !== af_prev) af_toggles++;
    af_prev = A_filtered[0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Gray state of the encoder for phase 0..3 as {A,B}
  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_ch(input int ch);
    logic [1:0] ab;
    ab = ab_of(ph[ch]);
    quadA[ch] = ab[1];
    quadB[ch] = ab[0];
  endtask

  task automatic step(input int ch, input int dir, input int len);
    ph[ch] = (ph[ch] + dir) & 3;
    drive_ch(ch);
    m_cnt[ch] = m_cnt[ch] + CW'(dir);
    repeat (len) @(negedge CLK);
  endtask

  task automatic settle();
    repeat (12) @(negedge CLK);
  endtask

  task automatic do_clear(input int ch);
    clear[ch] = 1'b1;
    repeat (2) @(negedge CLK);
    clear[ch] = 1'b0;
    m_cnt[ch] = '0;
    @(negedge CLK);
  endtask

  task automatic wait_vel(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge CLK);
      if (vel_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL vel_timeout: got no vel_valid expected pulse within 1200 cycles");
    end
  endtask

  // Scoreboard pop: compare the next expected velocity at a vel_valid pulse
  task automatic vel_expect(input int ch);
    bit seen;
    logic [VW-1:0] e;
    wait_vel(seen);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL vel_queue: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      if (seen) check($sformatf("velocity_ch%0d", ch), 32'(velocity[ch*VW +: VW]), 32'(e));
    end
  endtask

`ifdef QUAD_INDEX_EN
  task automatic idx_pulse();
    index[0] = 1'b1;
    repeat (8) @(negedge CLK);
    index[0] = 1'b0;
    settle();
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    logic [CW-1:0] old;
    int n;

    //            ch dir  n   len clr  exp_c0    exp_c1    err
    vecs[0] = '{0,  1, 400, 20, 1'b0, 10'd400,  10'd0,    2'b00};
    vecs[1] = '{1,  1,   7,  6, 1'b0, 10'd400,  10'd7,    2'b00};
    vecs[2] = '{0, -1,  12,  6, 1'b0, 10'd388,  10'd7,    2'b00};
    vecs[3] = '{1, -1,  12,  8, 1'b1, 10'd388,  10'h3F4,  2'b00};
    vecs[4] = '{0,  1,   5,  5, 1'b1, 10'd5,    10'h3F4,  2'b00};
    vecs[5] = '{0, -1,   1,  6, 1'b1, 10'h3FF,  10'h3F4,  2'b00};
    vecs[6] = '{1,  1,  12,  5, 1'b0, 10'h3FF,  10'd0,    2'b00};

    reset = 1'b1; quadA = '0; quadB = '0; index = '0; clear = '0; err_clr = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0;
      m_cnt[c] = '0;
    end
    repeat (3) @(negedge CLK);

    // Reset state
    check("reset_count", 32'(count), 32'd0);
    check("reset_velocity", 32'(velocity), 32'd0);
    check("reset_vel_valid", 32'(vel_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_A_filtered", 32'(A_filtered), 32'd0);
    reset = 1'b0;
    settle();

    // Table-driven step sequences
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_clr) do_clear(vecs[i].ch);
      for (int k = 0; k < vecs[i].nsteps; k++) step(vecs[i].ch, vecs[i].dir, vecs[i].ph_len);
      settle();
      check($sformatf("row%0d_count0", i), 32'(count[CW-1:0]), 32'(vecs[i].exp_c0));
      check($sformatf("row%0d_count1", i), 32'(count[2*CW-1:CW]), 32'(vecs[i].exp_c1));
      check($sformatf("row%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Latency: count moves exactly FLEN+3 edges after a clean input edge
    old = m_cnt[0];
    step(0, 1, 0);
    repeat (FLEN + 2) @(negedge CLK);
    check("latency_before", 32'(count[CW-1:0]), 32'(old));
    @(negedge CLK);
    check("latency_after", 32'(count[CW-1:0]), 32'(m_cnt[0]));
    settle();

    // Glitch filter: 4-cycle pulse rejected, 5- and 6-cycle pulses pass
    af_toggles = 0;
    quadA[0] = ~quadA[0];
    repeat (4) @(negedge CLK);
    quadA[0] = ~quadA[0];
    settle();
    check("glitch4_count", 32'(count[CW-1:0]), 32'(m_cnt[0]));
    check("glitch4_af_toggles", 32'(af_toggles), 32'd0);
    af_toggles = 0;
    quadA[0] = ~quadA[0];
    repeat (5) @(negedge CLK);
    quadA[0] = ~quadA[0];
    settle();
    check("pulse5_af_toggles", 32'(af_toggles), 32'd2);
    af_toggles = 0;
    quadA[0] = ~quadA[0];
    repeat (6) @(negedge CLK);
    quadA[0] = ~quadA[0];
    settle();
    check("pulse6_af_toggles", 32'(af_toggles), 32'd2);
    check("pulse6_count", 32'(count[CW-1:0]), 32'(m_cnt[0]));
    check("pulse6_err", 32'(err), 32'd0);

    // Illegal transition: both bits toggle together; set beats err_clr
    old = m_cnt[0];
    ph[0] = (ph[0] + 2) & 3;
    drive_ch(0);
    repeat (FLEN + 2) @(negedge CLK);
    check("illegal_err_before", 32'(err), 32'd0);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    check("err_set_beats_clr", 32'(err), 32'b01);
    repeat (10) @(negedge CLK);
    check("illegal_err_held", 32'(err), 32'b01);
    check("illegal_count", 32'(count[CW-1:0]), 32'(old));
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    @(negedge CLK);
    check("err_cleared", 32'(err), 32'd0);

    // Clear held: steps have no effect while clear is asserted
    clear[0] = 1'b1;
    for (int k = 0; k < 5; k++) step(0, 1, 6);
    settle();
    check("clear_held_count", 32'(count[CW-1:0]), 32'd0);
    clear[0] = 1'b0;
    m_cnt[0] = '0;
    settle();
    check("clear_release_count", 32'(count[CW-1:0]), 32'(m_cnt[0]));
    check("clear_other_ch", 32'(count[2*CW-1:CW]), 32'(m_cnt[1]));

    // Signed wrap: max positive + 1 -> most negative
    do_clear(0);
    for (int k = 0; k < 511; k++) step(0, 1, 5);
    settle();
    check("wrap_max", 32'(count[CW-1:0]), 32'h1FF);
    step(0, 1, 5);
    settle();
    check("wrap_min", 32'(count[CW-1:0]), 32'h200);

    // Velocity: 50 steps inside one window
    wait_vel(seen);
    exp_q.push_back(8'd50);
    for (int k = 0; k < 50; k++) step(0, 1, 6);
    vel_expect(0);
    check("velocity_ch1_idle", 32'(velocity[2*VW-1:VW]), 32'd0);

    // Velocity saturation, positive then negative
    wait_vel(seen);
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h7F);
    fork
      begin
        for (int k = 0; k < 350; k++) step(0, 1, 6);
      end
      begin
        vel_expect(0);
        vel_expect(0);
      end
    join
    settle();
    wait_vel(seen);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h80);
    fork
      begin
        for (int k = 0; k < 350; k++) step(0, -1, 6);
      end
      begin
        vel_expect(0);
        vel_expect(0);
      end
    join
    settle();

`ifdef QUAD_INDEX_EN
    // Index zeroing only at {A,B}=00; clear together with index gives 0
    while (ph[0] != 3) step(0, 1, 6);
    settle();
    do_clear(0);
    for (int k = 0; k < 37; k++) step(0, 1, 6);
    settle();
    check("index_pre_count", 32'(count[CW-1:0]), 32'd37);
    idx_pulse();
    m_cnt[0] = '0;
    check("index_at_00", 32'(count[CW-1:0]), 32'(m_cnt[0]));
    while (ph[0] != 1) step(0, 1, 6);
    settle();
    do_clear(0);
    for (int k = 0; k < 37; k++) step(0, 1, 6);
    settle();
    idx_pulse();
    check("index_at_11", 32'(count[CW-1:0]), 32'd37);
    clear[0] = 1'b1;
    idx_pulse();
    clear[0] = 1'b0;
    m_cnt[0] = '0;
    settle();
    check("index_with_clear", 32'(count[CW-1:0]), 32'd0);
`endif

    // Reset mid-operation: immediate return to reset values, window restarts
    ph[0] = 1;
    drive_ch(0);
    settle();
    check("pre_reset_A_filtered", 32'(A_filtered[0]), 32'd1);
    @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_velocity", 32'(velocity), 32'd0);
    check("midreset_err", 32'(err), 32'd0);
    check("midreset_A_filtered", 32'(A_filtered), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0;
      drive_ch(c);
      m_cnt[c] = '0;
    end
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge CLK);
      n++;
      #1;
      if (vel_valid) break;
    end
    check("window_restart", 32'(n), 32'(WIN));
    check("post_reset_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
